grid_scan_display: RTL and testbench
====================================

Name: grid_scan_display

Overview:
Reader side of the cellular-automaton grid. It samples the 4x4 `cellStatus` grid that the game-of-life core produces, once per frame, into a tear-free frame buffer. It then row-multiplexes that buffer onto the DE1-SoC LED matrix as a one-hot row select plus column data. It also reports a live-cell count for the HEX display.

Parameters:
- GRID_SIZE, 4: rows and columns of the square grid; must match the game core.
- DWELL, 1024: clk cycles each row is driven; must be >= 1.
- BLANK_CYCLES, 16: dark cycles after each row; used only when GRID_SCAN_BLANK_EN is defined; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cellStatus  in  [GRID_SIZE-1:0][GRID_SIZE-1:0]  live grid, indexed [row][col], 1 = alive.
- hold  in  1  when 1, the frame-load step keeps the previous buffer instead of resampling.
- row_sel  out  GRID_SIZE  one-hot active-high row drive; all zero when dark.
- col_data  out  GRID_SIZE  bit c = frame_buf[active row][c]; zero when dark.
- frame_start  out  1  one-cycle pulse in the first cycle row 0 is lit.
- live_count  out  $clog2(GRID_SIZE*GRID_SIZE+1)  popcount of the current frame buffer.

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high.
- All outputs are registered.
- While `reset` is high, every output and internal register is 0: row_sel=0, col_data=0, frame_start=0, live_count=0, frame_buf=0, row counter=0, prescaler=0. The state is S_LOAD.
- Reset mid-frame aborts the scan immediately at that edge, with no partial row.
- State S_LOAD, exactly 1 cycle, outputs dark:
  - If hold=0 at the edge, frame_buf <= cellStatus and live_count <= popcount(cellStatus) in the same edge.
  - If hold=1, frame_buf and live_count are unchanged. After reset, holding yields an all-zero frame.
  - Next state S_SCAN with row=0, prescaler=0. At the same edge row_sel <= 1<<0, col_data <= the newly loaded row 0, frame_start <= 1.
- State S_SCAN:
  - row_sel = 1<<row; col_data = frame_buf[row]; prescaler increments every cycle.
  - frame_start is high only on the first S_SCAN cycle of row 0.
  - When prescaler == DWELL-1, prescaler clears. The next state is S_BLANK if blanking is compiled in. Otherwise it is row+1 in S_SCAN, or S_LOAD if row == GRID_SIZE-1.
- Each row is lit for exactly DWELL consecutive cycles. The row counter wraps GRID_SIZE-1 -> 0, and only via S_LOAD.
- Frame period is GRID_SIZE*DWELL + 1 cycles (GRID_SIZE*(DWELL+BLANK_CYCLES) + 1 with blanking).
- Changes on cellStatus between loads never affect row_sel, col_data or live_count: no tearing.
- hold is sampled only in S_LOAD and ignored in all other states.
- live_count changes only on the S_LOAD edge. Its maximum value GRID_SIZE^2 must fit: 16 needs 5 bits.
- Elaboration error if DWELL < 1, or if GRID_SIZE < 2.

Optional Feature:
- Macro `GRID_SCAN_BLANK_EN`.
- Defined: a state S_BLANK of BLANK_CYCLES cycles follows every row, including the last, before the next row or S_LOAD. During S_BLANK, row_sel=0 and col_data=0; this is anti-ghosting.
- Undefined: the S_BLANK state and its counter are not synthesised, BLANK_CYCLES is ignored, and rows are back-to-back. The S_LOAD cycle still gives 1 dark cycle per frame.

Decomposition:
- Package `grid_pkg`:
  - GRID_SIZE default constant.
  - typedef `grid_t` = logic [GRID_SIZE-1:0][GRID_SIZE-1:0].
  - enum `scan_state_e` {S_LOAD, S_SCAN, S_BLANK}.
  - function `cnt_w(n)` returning $clog2(n+1).
- One sub-module: `grid_popcount`, a purely combinational `grid_t` -> count adder tree, reused later by the HEX driver.

Test Plan:
- Run with GRID_SIZE=4, DWELL=3, blanking off.
- Reset release, cellStatus rows = {0001, 0010, 0100, 1000} (row 0 first):
  - frame_start on cycle 2.
  - row_sel 0001/col_data 0001 for 3 cycles, then 0010/0010, 0100/0100, 1000/1000.
  - 1 dark cycle, then repeat; period 13.
  - live_count=4.
- Change cellStatus to all-ones during row 1 of a frame: the rest of that frame still shows the diagonal. The next frame shows col_data 1111 on every row and live_count=16.
- hold=1 across an S_LOAD with cellStatus=0: display and live_count=4 persist. Drop hold: the next frame goes dark and live_count=0.
- Assert reset during row 2: outputs are 0 on the next edge. After release, the first frame restarts at row 0 with frame_start.
- With `GRID_SCAN_BLANK_EN`, BLANK_CYCLES=2: each 3-cycle row is followed by 2 cycles of row_sel=0 and col_data=0; period 21.
- Random grids for 1000 frames: the scoreboard checks the one-hot row_sel invariant and that live_count equals the popcount of the sampled grid.

Source files
------------

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared types, constants and helpers for the grid scan display.
package grid_pkg;

  localparam int GRID_SIZE = 4;

  typedef logic [GRID_SIZE-1:0][GRID_SIZE-1:0] grid_t;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SCAN  = 2'd1,
    S_BLANK = 2'd2
  } scan_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/grid_popcount.sv
// rtl/grid_popcount.sv - combinational live-cell count of an NxN grid (per-row sums, then total).
module grid_popcount #(
  parameter int N  = grid_pkg::GRID_SIZE,
  parameter int CW = grid_pkg::cnt_w(N * N)
) (
  input  logic [N-1:0][N-1:0] grid,
  output logic [CW-1:0]       count
);

  localparam int RCW = grid_pkg::cnt_w(N);

  logic [N-1:0][RCW-1:0] row_cnt;

  always_comb begin
    row_cnt = '0;
    count   = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        row_cnt[r] = row_cnt[r] + RCW'(grid[r][c]);
      end
      count = count + CW'(row_cnt[r]);
    end
  end

endmodule

// File: rtl/grid_scan_display.sv
// rtl/grid_scan_display.sv - tear-free frame sampler and row-multiplexed LED matrix driver.
// Define GRID_SCAN_BLANK_EN to insert BLANK_CYCLES dark cycles after every row.
module grid_scan_display #(
  parameter int GRID_SIZE    = grid_pkg::GRID_SIZE,
  parameter int DWELL        = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [GRID_SIZE-1:0][GRID_SIZE-1:0]        cellStatus,
  input  logic                                       hold,
  output logic [GRID_SIZE-1:0]                       row_sel,
  output logic [GRID_SIZE-1:0]                       col_data,
  output logic                                       frame_start,
  output logic [$clog2(GRID_SIZE*GRID_SIZE+1)-1:0]   live_count
);
  import grid_pkg::*;

  localparam int RW  = $clog2(GRID_SIZE);
  localparam int PW  = cnt_w(DWELL);
  localparam int LCW = cnt_w(GRID_SIZE * GRID_SIZE);

  if (DWELL < 1 || GRID_SIZE < 2 || BLANK_CYCLES < 1) begin : g_bad_cfg
    $error("grid_scan_display: invalid DWELL, GRID_SIZE or BLANK_CYCLES");
  end

  scan_state_e                         state_q, state_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [PW-1:0]                       presc_q, presc_d;
  logic [GRID_SIZE-1:0][GRID_SIZE-1:0] buf_q, buf_d;
  logic [LCW-1:0]                      live_q, live_d;
  logic [GRID_SIZE-1:0]                row_sel_q, row_sel_d;
  logic [GRID_SIZE-1:0]                col_data_q, col_data_d;
  logic                                frame_start_q, frame_start_d;
  logic [LCW-1:0]                      pop_count;
  logic                                row_done;
`ifdef GRID_SCAN_BLANK_EN
  localparam int BW = cnt_w(BLANK_CYCLES);
  logic [BW-1:0]                       blank_q, blank_d;
`endif

  grid_popcount #(.N(GRID_SIZE), .CW(LCW)) u_popcount (
    .grid  (cellStatus),
    .count (pop_count)
  );

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    presc_d       = presc_q;
    buf_d         = buf_q;
    live_d        = live_q;
    row_sel_d     = '0;
    col_data_d    = '0;
    frame_start_d = 1'b0;
    row_done      = 1'b0;
`ifdef GRID_SCAN_BLANK_EN
    blank_d       = blank_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (!hold) begin
          buf_d  = cellStatus;
          live_d = pop_count;
        end
        state_d       = S_SCAN;
        row_d         = '0;
        presc_d       = '0;
        row_sel_d     = GRID_SIZE'(1);
        col_data_d    = buf_d[0];
        frame_start_d = 1'b1;
      end
      S_SCAN: begin
        row_sel_d  = row_sel_q;
        col_data_d = col_data_q;
        presc_d    = presc_q + PW'(1);
        if (presc_q == PW'(DWELL - 1)) begin
          presc_d = '0;
`ifdef GRID_SCAN_BLANK_EN
          state_d    = S_BLANK;
          blank_d    = '0;
          row_sel_d  = '0;
          col_data_d = '0;
`else
          row_done   = 1'b1;
`endif
        end
      end
`ifdef GRID_SCAN_BLANK_EN
      S_BLANK: begin
        blank_d = blank_q + BW'(1);
        if (blank_q == BW'(BLANK_CYCLES - 1)) begin
          blank_d  = '0;
          row_done = 1'b1;
        end
      end
`endif
      default: state_d = S_LOAD;
    endcase

    // The only way back to row 0 is through S_LOAD, which resamples the frame.
    if (row_done) begin
      if (row_q == RW'(GRID_SIZE - 1)) begin
        state_d    = S_LOAD;
        row_sel_d  = '0;
        col_data_d = '0;
      end else begin
        state_d    = S_SCAN;
        row_d      = row_q + RW'(1);
        row_sel_d  = GRID_SIZE'(1) << row_d;
        col_data_d = buf_q[row_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LOAD;
      row_q         <= '0;
      presc_q       <= '0;
      buf_q         <= '0;
      live_q        <= '0;
      row_sel_q     <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
`ifdef GRID_SCAN_BLANK_EN
      blank_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      presc_q       <= presc_d;
      buf_q         <= buf_d;
      live_q        <= live_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
`ifdef GRID_SCAN_BLANK_EN
      blank_q       <= blank_d;
`endif
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;
  assign live_count  = live_q;

endmodule

// File: tb/tb_grid_scan_display.sv
// tb/tb_grid_scan_display.sv - directed frame table, reset/hold sequences and random frames.
module tb_grid_scan_display;

  localparam int DWELL = 3;
`ifdef GRID_SCAN_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif

  logic             clk;
  logic             reset;
  logic [3:0][3:0]  cellStatus;
  logic             hold;
  logic [3:0]       row_sel;
  logic [3:0]       col_data;
  logic             frame_start;
  logic [4:0]       live_count;

  int n_checks = 0;
  int n_fail   = 0;

  grid_scan_display #(.GRID_SIZE(4), .DWELL(DWELL), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cellStatus  (cellStatus),
    .hold        (hold),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .live_count  (live_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] grid;
    logic        hold;
    logic        mid_en;
    logic [15:0] mid_grid;
    logic [15:0] exp_rows;
    logic [4:0]  exp_live;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dark(input logic [4:0] exp_live);
    chk("dark_row_sel", 32'(row_sel), 32'd0);
    chk("dark_col_data", 32'(col_data), 32'd0);
    chk("dark_frame_start", 32'(frame_start), 32'd0);
    chk("live_count", 32'(live_count), 32'(exp_live));
  endtask

  // Runs one frame starting at the S_LOAD edge; stops early after max_ticks edges.
  task automatic do_frame(input logic [15:0] g, input logic h, input logic mid_en,
                          input logic [15:0] mg, input logic [15:0] exp_rows,
                          input logic [4:0] exp_live, input int max_ticks);
    int t;
    t = 0;
    cellStatus = g;
    hold       = h;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < DWELL + BL; k++) begin
        if (t >= max_ticks) return;
        tick();
        t++;
        if (k < DWELL) begin
          chk("row_sel", 32'(row_sel), 32'(4'b0001 << r));
          chk("col_data", 32'(col_data), 32'(exp_rows[r*4 +: 4]));
          chk("frame_start", 32'(frame_start), 32'((r == 0) && (k == 0)));
          chk("live_count", 32'(live_count), 32'(exp_live));
        end else begin
          chk_dark(exp_live);
        end
        if (mid_en && r == 1 && k == 0) cellStatus = mg;
      end
    end
    if (t >= max_ticks) return;
    tick();
    chk_dark(exp_live);
  endtask

  initial begin
    logic [15:0] g;
    logic [15:0] mbuf;
    logic        h;

    vecs[0] = '{16'h8421, 1'b0, 1'b0, 16'h0000, 16'h8421, 5'd4};
    vecs[1] = '{16'h8421, 1'b0, 1'b1, 16'hFFFF, 16'h8421, 5'd4};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 5'd16};
    vecs[3] = '{16'h8421, 1'b0, 1'b0, 16'h0000, 16'h8421, 5'd4};
    vecs[4] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 16'h8421, 5'd4};
    vecs[5] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0};
    vecs[6] = '{16'h1234, 1'b0, 1'b0, 16'h0000, 16'h1234, 5'd5};
    vecs[7] = '{16'hA5F0, 1'b1, 1'b0, 16'h0000, 16'h1234, 5'd5};
    vecs[8] = '{16'hA5F0, 1'b0, 1'b0, 16'h0000, 16'hA5F0, 5'd8};

    reset      = 1'b1;
    hold       = 1'b0;
    cellStatus = 16'hFFFF;
    repeat (3) tick();
    chk("rst_row_sel", 32'(row_sel), 32'd0);
    chk("rst_col_data", 32'(col_data), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_live_count", 32'(live_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_frame(vecs[i].grid, vecs[i].hold, vecs[i].mid_en, vecs[i].mid_grid,
               vecs[i].exp_rows, vecs[i].exp_live, 1000);
    end

    // Abort mid row 2, then hold across the first load after reset.
    do_frame(16'h8421, 1'b0, 1'b0, 16'h0, 16'h8421, 5'd4, 2 * (DWELL + BL) + 2);
    reset = 1'b1;
    tick();
    chk("midrst_row_sel", 32'(row_sel), 32'd0);
    chk("midrst_col_data", 32'(col_data), 32'd0);
    chk("midrst_frame_start", 32'(frame_start), 32'd0);
    chk("midrst_live_count", 32'(live_count), 32'd0);
    reset = 1'b0;
    do_frame(16'hFFFF, 1'b1, 1'b0, 16'h0, 16'h0000, 5'd0, 1000);
    do_frame(16'h8421, 1'b0, 1'b0, 16'h0, 16'h8421, 5'd4, 1000);

    mbuf = 16'h0;
    for (int f = 0; f < 1000; f++) begin
      g = 16'($urandom);
      h = (f == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      if (!h) mbuf = g;
      do_frame(g, h, 1'b0, 16'h0, mbuf, 5'($countones(mbuf)), 1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
